// File: rtl/os_column_drain.sv
// Output drain for one systolic-array column: snapshot the column's MAC words, pulse a clear,
// then stream them row 0 first. Define DRAIN_SATURATE_EN to clamp words to OUT_W bits instead of truncating.
module os_column_drain #(
  parameter int ROWS      = 4,
  parameter int WIDTH_MAC = 48,
  parameter int OUT_W     = 32,
  parameter int SIGNED    = 0,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*WIDTH_MAC-1:0] mac_in,
  input  logic                      mac_valid,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic [ROW_W-1:0]          out_row,
  output logic                      out_last,
  output logic                      out_sat,
  output logic                      busy,
  output logic                      clear_out,
  output logic                      overrun
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, next_state;

  logic [ROW_W-1:0]     row_cnt;
  logic [WIDTH_MAC-1:0] mac_word  [ROWS];
  logic [OUT_W-1:0]     conv_data [ROWS];
  logic [ROWS-1:0]      conv_sat;
  logic [OUT_W-1:0]     data_buf  [ROWS];
  logic [ROWS-1:0]      sat_buf;
  logic                 capture;
  logic                 last_row;

  assign capture  = (state == IDLE) && mac_valid;
  assign last_row = (row_cnt == ROW_W'(ROWS - 1));

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      mac_word[r] = mac_in[r*WIDTH_MAC +: WIDTH_MAC];
    end
  end

`ifdef DRAIN_SATURATE_EN
  // Shift-based limits stay valid for OUT_W == WIDTH_MAC, where nothing can exceed them.
  localparam logic [WIDTH_MAC-1:0] UMAX = (WIDTH_MAC'(1) << OUT_W) - WIDTH_MAC'(1);
  localparam logic [WIDTH_MAC-1:0] SMAX = (WIDTH_MAC'(1) << (OUT_W - 1)) - WIDTH_MAC'(1);
  localparam logic [WIDTH_MAC-1:0] SMIN = ~SMAX;

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      conv_data[r] = mac_word[r][OUT_W-1:0];
      conv_sat[r]  = 1'b0;
      if (SIGNED != 0) begin
        if ($signed(mac_word[r]) > $signed(SMAX)) begin
          conv_data[r] = SMAX[OUT_W-1:0];
          conv_sat[r]  = 1'b1;
        end else if ($signed(mac_word[r]) < $signed(SMIN)) begin
          conv_data[r] = SMIN[OUT_W-1:0];
          conv_sat[r]  = 1'b1;
        end
      end else if (mac_word[r] > UMAX) begin
        conv_data[r] = UMAX[OUT_W-1:0];
        conv_sat[r]  = 1'b1;
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{mac_in, SIGNED[0]};

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      conv_data[r] = mac_word[r][OUT_W-1:0];
      conv_sat[r]  = 1'b0;
    end
  end
`endif

  // Words are converted on the way in, so draining adds no conversion latency.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < ROWS; r++) begin
        data_buf[r] <= conv_data[r];
      end
      sat_buf <= conv_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mac_valid) next_state = DRAIN;
      DRAIN:   if (out_ready && last_row) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt   <= '0;
      clear_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      clear_out <= capture;
      if (state == DRAIN) begin
        if (mac_valid) overrun <= 1'b1;
        if (out_ready) row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end else if (capture) begin
        row_cnt <= '0;
      end
    end
  end

  assign busy      = (state == DRAIN);
  assign out_valid = busy;
  assign out_data  = busy ? data_buf[row_cnt] : '0;
  assign out_row   = busy ? row_cnt : '0;
  assign out_last  = busy && last_row;
  assign out_sat   = busy && sat_buf[row_cnt];

endmodule

// File: tb/tb_os_column_drain.sv
// Bench for os_column_drain: an unsigned and a signed instance share stimulus and are checked
// against a word-level model (honours DRAIN_SATURATE_EN when defined).
module tb_os_column_drain;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][47:0] mac_in;
  logic             mac_valid;
  logic             out_ready;

  logic [1:0]       ovalid, olast, osat, obusy, oclear, oovr;
  logic [1:0][31:0] odata;
  logic [1:0][1:0]  orow;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_overrun = 1'b0;

  always #5 clk = ~clk;

  os_column_drain #(.ROWS(4), .WIDTH_MAC(48), .OUT_W(32), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .mac_in(mac_in), .mac_valid(mac_valid), .out_ready(out_ready),
    .out_valid(ovalid[0]), .out_data(odata[0]), .out_row(orow[0]), .out_last(olast[0]),
    .out_sat(osat[0]), .busy(obusy[0]), .clear_out(oclear[0]), .overrun(oovr[0])
  );

  os_column_drain #(.ROWS(4), .WIDTH_MAC(48), .OUT_W(32), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .mac_in(mac_in), .mac_valid(mac_valid), .out_ready(out_ready),
    .out_valid(ovalid[1]), .out_data(odata[1]), .out_row(orow[1]), .out_last(olast[1]),
    .out_sat(osat[1]), .busy(obusy[1]), .clear_out(oclear[1]), .overrun(oovr[1])
  );

  // Reference conversion from the numeric value of the word, not from bit tricks.
  function automatic logic [31:0] conv_model(input logic [47:0] w, input bit sgn, output bit sat);
    longint v;
    sat = 1'b0;
`ifdef DRAIN_SATURATE_EN
    if (!sgn) begin
      if (w > 48'h0000_FFFF_FFFF) begin
        sat = 1'b1;
        return 32'hFFFF_FFFF;
      end
    end else begin
      v = longint'($signed(w));
      if (v > (64'sd1 <<< 31) - 64'sd1) begin
        sat = 1'b1;
        return 32'h7FFF_FFFF;
      end
      if (v < -(64'sd1 <<< 31)) begin
        sat = 1'b1;
        return 32'h8000_0000;
      end
    end
`else
    v = longint'(sgn);
`endif
    return w[31:0];
  endfunction

  function automatic logic [47:0] rand_word();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: return {16'h0, a};
      1: return {b[15:0], a};
      2: return 48'(-longint'($urandom_range(1, 100000)));
      default: begin
        case ($urandom_range(0, 5))
          0: return 48'h0000_FFFF_FFFF;
          1: return 48'h0001_0000_0000;
          2: return 48'h0000_7FFF_FFFF;
          3: return 48'h0000_8000_0000;
          4: return 48'hFFFF_8000_0000;
          default: return 48'hFFFF_7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  // One capture plus drain. ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
  // inject_at: drain cycle that also pulses mac_valid; abort_after: transfers before rst.
  task automatic drain_once(input logic [3:0][47:0] words, input int ready_mode,
                            input int inject_at, input int abort_after);
    int row = 0;
    int cyc = 0;
    logic [31:0] ed;
    bit es, rdy;
    mac_in    = words;
    mac_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mac_valid = 1'b0;
    mac_in    = '0;
    while (row < 4) begin
      for (int d = 0; d < 2; d++) begin
        ed = conv_model(words[row], d[0], es);
        vectors++;
        if (ovalid[d] !== 1'b1 || obusy[d] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL valid/busy dut%0d row%0d: got %b/%b want 1/1", d, row, ovalid[d], obusy[d]);
        end
        vectors++;
        if (odata[d] !== ed) begin
          miscompares++;
          $display("[TB] FAIL data dut%0d row%0d: got %h want %h", d, row, odata[d], ed);
        end
        vectors++;
        if (orow[d] !== 2'(row) || olast[d] !== (row == 3)) begin
          miscompares++;
          $display("[TB] FAIL row/last dut%0d: got %0d/%b want %0d/%b", d, orow[d], olast[d], row, row == 3);
        end
        vectors++;
        if (osat[d] !== es) begin
          miscompares++;
          $display("[TB] FAIL sat dut%0d row%0d: got %b want %b", d, row, osat[d], es);
        end
        vectors++;
        if (oclear[d] !== (cyc == 0) || oovr[d] !== exp_overrun) begin
          miscompares++;
          $display("[TB] FAIL clear/overrun dut%0d cyc%0d: got %b/%b want %b/%b",
                   d, cyc, oclear[d], oovr[d], cyc == 0, exp_overrun);
        end
      end
      if (cyc >= 200) begin
        miscompares++;
        $display("[TB] FAIL drain timeout: got %0d rows want 4", row);
        break;
      end
      if (abort_after >= 0 && row == abort_after) begin
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if ({ovalid[d], odata[d], orow[d], olast[d], osat[d], obusy[d], oclear[d], oovr[d]} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async reset dut%0d: got valid=%b data=%h busy=%b ovr=%b want all 0",
                     d, ovalid[d], odata[d], obusy[d], oovr[d]);
          end
        end
        #2 rst = 1'b0;
        exp_overrun = 1'b0;
        @(negedge clk);
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (cyc == inject_at) begin
        mac_valid   = 1'b1;
        mac_in      = {4{48'd9}};
        exp_overrun = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      mac_valid = 1'b0;
      mac_in    = '0;
      if (rdy) row++;
      cyc++;
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({ovalid[d], odata[d], orow[d], olast[d], osat[d], obusy[d], oclear[d]} !== '0 ||
          oovr[d] !== exp_overrun) begin
        miscompares++;
        $display("[TB] FAIL idle after drain dut%0d: got valid=%b busy=%b data=%h ovr=%b want 0/0/0/%b",
                 d, ovalid[d], obusy[d], odata[d], oovr[d], exp_overrun);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mac_valid = 1'b0;
    out_ready = 1'b0;
    mac_in    = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({ovalid[d], odata[d], orow[d], olast[d], osat[d], obusy[d], oclear[d], oovr[d]} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset dut%0d: got valid=%b data=%h busy=%b clr=%b want all 0",
                 d, ovalid[d], odata[d], obusy[d], oclear[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drain_once({48'd4, 48'd3, 48'd2, 48'd1}, 0, -1, -1);
  endtask

  task automatic test_stall();
    drain_once({48'd4, 48'd3, 48'd2, 48'd1}, 1, -1, -1);
  endtask

  task automatic test_saturation();
    drain_once({48'h0000_7FFF_FFFF, 48'hFFFF_FFFF_FFF9, 48'hFF00_0000_0000, 48'h0001_0000_0005}, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    drain_once({48'd14, 48'd13, 48'd12, 48'd11}, 0, -1, -1);
    drain_once({48'd24, 48'd23, 48'd22, 48'd21}, 0, -1, -1);
  endtask

  task automatic test_mid_reset();
    drain_once({48'd8, 48'd7, 48'd6, 48'd5}, 0, -1, 2);
    drain_once({48'd40, 48'd30, 48'd20, 48'd10}, 0, -1, -1);
  endtask

  task automatic test_overrun();
    drain_once({48'd4, 48'd3, 48'd2, 48'd1}, 0, 1, -1);
    drain_once({48'd4, 48'd3, 48'd2, 48'd1}, 0, 3, -1);
    drain_once({48'd5, 48'd6, 48'd7, 48'd8}, 2, -1, -1);
  endtask

  task automatic test_random();
    logic [3:0][47:0] w;
    int inj;
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < 4; r++) w[r] = rand_word();
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      drain_once(w, 2, inj, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    test_overrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
